// File: rtl/enable_switch_conditioner_pkg.sv
// Shared definitions for the switch/key conditioner family: debounce state
// encoding, glitch counter width and a saturating increment helper.
package enable_switch_conditioner_pkg;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_QUALIFY = 1'b1;

    localparam int GLITCH_W = 8;

    typedef enum logic {
        IDLE    = ST_IDLE,
        QUALIFY = ST_QUALIFY
    } dbn_state_t;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] value);
        logic [GLITCH_W-1:0] result;
        result = (&value) ? value : value + GLITCH_W'(1);
        return result;
    endfunction

endpackage

// File: rtl/enable_switch_conditioner_if.sv
// Signal bundle between the board switch side and the enable switch conditioner.
interface enable_switch_conditioner_if;
    import enable_switch_conditioner_pkg::*;

    logic                raw_in;
    logic                glitch_clr;
    logic                level_out;
    logic                rise_pulse;
    logic                fall_pulse;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output raw_in,
        output glitch_clr,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  glitch_cnt
    );

    modport slave (
        input  raw_in,
        input  glitch_clr,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output glitch_cnt
    );

endinterface

// File: rtl/enable_switch_conditioner_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; d feeds the first
// flop directly so nothing combinational sits in front of the capture stage.
module bit_synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("bit_synchronizer: STAGES must be at least 2");
    end

    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_reg <= {STAGES{RESET_VAL}};
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/enable_switch_conditioner.sv
// Enable-switch conditioner: synchronises and debounces the raw board switch,
// drives a clean level plus one-cycle edge strobes and a saturating glitch count.
module enable_switch_conditioner
    import enable_switch_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    enable_switch_conditioner_if.slave  sw
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("enable_switch_conditioner: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("enable_switch_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end

    logic sync_out;

    bit_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sw.raw_in),
        .q       (sync_out)
    );

    dbn_state_t          state_reg,  state_next;
    logic [CNT_W-1:0]    cnt_reg,    cnt_next;
    logic                level_reg,  level_next;
    logic                rise_reg,   rise_next;
    logic                fall_reg,   fall_next;
    logic [GLITCH_W-1:0] glitch_reg, glitch_next;
    logic                abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            level_reg  <= RESET_LEVEL;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            glitch_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            level_reg  <= level_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
            glitch_reg <= glitch_next;
        end
    end

    // cnt holds the number of consecutive edges sync_out has disagreed with
    // level_out; a single agreeing sample throws all progress away.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        level_next  = level_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        glitch_next = glitch_reg;
        abort       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sync_out != level_reg) begin
                    state_next = QUALIFY;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            QUALIFY: begin
                if (sync_out == level_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    abort      = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    level_next = sync_out;
                    rise_next  = sync_out;
                    fall_next  = ~sync_out;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // A clear in the same cycle as an abort leaves the counter at zero.
        if (sw.glitch_clr) begin
            glitch_next = '0;
        end else if (abort) begin
            glitch_next = sat_inc(glitch_reg);
        end
    end

    assign sw.level_out  = level_reg;
    assign sw.rise_pulse = rise_reg;
    assign sw.fall_pulse = fall_reg;
    assign sw.glitch_cnt = glitch_reg;

endmodule
